// File: rtl/dual_port_memory_sync.sv
// Purpose: single-clock simple dual-port RAM (1R/1W) with byte-lane write mask,
//          optional read-during-write bypass and an automatic post-reset zero-fill.
// Latency: read data and read_valid one cycle after read_enable; writes land on the next edge.
// Backpressure: none per request; ready stays low during the post-reset clear and
//               requests issued while it is low are dropped.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   ready                high once the array accepts read/write requests
//   read_enable/addr     read request; read_data/read_valid returned next cycle
//   write_enable/addr    write request; write_mask selects BYTE_WIDTH lanes of write_data
module dual_port_memory_sync #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 512,
  parameter int BYTE_WIDTH     = 8,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          ready,
  input  logic                          read_enable,
  input  logic [$clog2(DEPTH)-1:0]      read_addr,
  output logic [WIDTH-1:0]              read_data,
  output logic                          read_valid,
  input  logic                          write_enable,
  input  logic [$clog2(DEPTH)-1:0]      write_addr,
  input  logic [WIDTH/BYTE_WIDTH-1:0]   write_mask,
  input  logic [WIDTH-1:0]              write_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = WIDTH / BYTE_WIDTH;
  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  generate
    if ((WIDTH % BYTE_WIDTH) != 0 || DEPTH < 2) begin : g_bad_params
      $fatal(1, "dual_port_memory_sync: WIDTH must be a multiple of BYTE_WIDTH and DEPTH >= 2");
    end
  endgenerate

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clear_addr_q, clear_addr_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic            read_valid_q, read_valid_d;

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port into the array, shared between the clear walker and user writes.
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [LANES-1:0] mem_be;
  logic [WIDTH-1:0] mem_wdata;

  logic             rd_in_range;
  logic             wr_in_range;
  logic             rd_hit;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] merged;

  always_comb begin
    rd_in_range = ({1'b0, read_addr} < DEPTH_W);
    wr_in_range = ({1'b0, write_addr} < DEPTH_W);

    // Old contents of the read address; out-of-range reads return zero.
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[read_addr];
    end

    // Old word with the masked lanes of the incoming write substituted.
    merged = rd_word;
    for (int i = 0; i < LANES; i++) begin
      if (write_mask[i]) begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    // Equal addresses with an in-range write imply an in-range read.
    rd_hit = write_enable && wr_in_range && (read_addr == write_addr);

    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = write_addr;
    mem_be       = write_mask;
    mem_wdata    = write_data;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clear_addr_q;
        mem_be    = '1;
        mem_wdata = '0;
        if (clear_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
        end
      end
      ST_RUN: begin
        mem_we = write_enable && wr_in_range;
        if (read_enable) begin
          read_valid_d = 1'b1;
          read_data_d  = ((BYPASS != 0) && rd_hit) ? merged : rd_word;
        end
      end
    endcase

    // Nothing reaches the array while reset is held; the clear restarts afterwards.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clear_addr_q <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  // Storage array: no reset so it maps onto block RAM with byte enables.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign ready      = (state_q == ST_RUN);
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: doc/dual_port_memory_sync.md
Name: dual_port_memory_sync

Overview:
Single-clock, parametrised simple dual-port RAM: one read port and one write port. Generalises the basic dual-port memory with:
- arbitrary width and depth, including non-power-of-two depth
- per-byte write masking
- selectable read-during-write bypass
- a registered read-valid strobe
- an automatic post-reset clear sequence with a ready flag

Used as the backing store for FIFOs, line buffers and register files throughout the design.

Parameters:
WIDTH, 16, data word width in bits; must be a multiple of BYTE_WIDTH.
DEPTH, 512, number of words; need not be a power of two.
BYTE_WIDTH, 8, bits per write-mask lane.
BYPASS, 1, 1 = same-address read during write returns new data; 0 = returns old data.
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting traffic; 0 = contents untouched, ready immediately.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
ready  output  1  high when the block accepts read/write requests.
read_enable  input  1  read request this cycle.
read_addr  input  $clog2(DEPTH)  read word address.
read_data  output  WIDTH  registered read data.
read_valid  output  1  one-cycle strobe: read_data updated this cycle.
write_enable  input  1  write request this cycle.
write_addr  input  $clog2(DEPTH)  write word address.
write_mask  input  WIDTH/BYTE_WIDTH  per-lane write enable; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
write_data  input  WIDTH  write data.

Behaviour:
- Elaboration: WIDTH % BYTE_WIDTH != 0 or DEPTH < 2 is a fatal elaboration error.
- Reset (synchronous, active-high, while asserted and on the cycle it is sampled):
  - read_data = 0, read_valid = 0.
  - ready = 0 if CLEAR_ON_RESET, else 1.
  - Clear address = 0.
  - FSM enters CLEAR if CLEAR_ON_RESET, else RUN.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes all-zero to mem[clear_addr] and increments clear_addr. After writing DEPTH-1, go to RUN. ready rises the cycle after the final clear write. Clear therefore takes exactly DEPTH cycles after reset deasserts.
  - In CLEAR: read_enable and write_enable are ignored, read_valid stays 0, read_data holds 0.
  - Reset asserted mid-clear restarts the clear from address 0.
  - RUN: no exit except reset.
- Write (RUN, write_enable=1): for each lane i with write_mask[i]=1, mem[write_addr] lane i takes write_data lane i. Unmasked lanes are unchanged. An all-zero mask is a no-op.
- Read (RUN, read_enable=1): request at cycle N gives read_data = mem[read_addr] and read_valid = 1 at cycle N+1. Latency is fixed at 1; back-to-back reads are allowed every cycle.
- read_enable=0: read_valid = 0 next cycle; read_data holds its last value.
- Same-address read and write in the same cycle:
  - BYPASS=1: read_data = old word with masked lanes replaced by write_data lanes.
  - BYPASS=0: read_data = old word.
  - Memory is updated in both cases.
- Out-of-range addresses (addr >= DEPTH, possible when DEPTH is not a power of two):
  - Writes are dropped.
  - Reads return 0 with read_valid = 1.
  - Bypass never applies to an out-of-range address.
- No other internal state. Storage is inferred as block RAM; the bypass path and mask merge are the only logic outside the array.

Test Plan:
- Clear sequence (DEPTH=512, CLEAR_ON_RESET=1): deassert reset -> ready=0 for exactly 512 cycles, then 1. Reads to 0, 255 and 511 return 0x0000 with read_valid=1.
- Masked write: write 0xABCD mask 2'b11 to addr 5, then 0x1200 mask 2'b10 to addr 5, then read 5 -> read_data = 0x12CD one cycle after the request.
- Bypass: pre-load addr 9 = 0x1111, then same-cycle write 0x2222 mask 2'b01 and read addr 9 -> BYPASS=1 returns 0x1122; BYPASS=0 returns 0x1111; a later read returns 0x1122 in both builds.
- Reset mid-clear: assert reset for one cycle at clear cycle 100 -> ready stays 0 until 512 cycles after that reset deasserts. Requests issued during clear produce no read_valid.
- Non-power-of-two (DEPTH=300): write 0xFFFF to addr 300, then read 300 -> read_data = 0, read_valid = 1. Read 299 returns its prior value, unaffected.
- Streaming: reads to addresses 0..15 on consecutive cycles after writing data = addr*3 -> read_valid high for 16 consecutive cycles, data 0, 3, …, 45 in order.
